// File: rtl/down_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle done pulse.
// Define DOWN_TIMER_RELOAD_EN for periodic mode (DONE re-enters RUN from a reload register).
module down_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             count,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic             busy_q;
    logic             done_q;
`ifdef DOWN_TIMER_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    // busy/done are registered alongside the state so they always match it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DOWN_TIMER_RELOAD_EN
            reload_q <= '0;
`endif
        end else if (load) begin
            state_q  <= IDLE;
            count_q  <= load_val;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DOWN_TIMER_RELOAD_EN
            reload_q <= load_val;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_q != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (count && (count_q != '0)) begin
                        count_q <= count_q - ONE;
                        if (count_q == ONE) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
`ifdef DOWN_TIMER_RELOAD_EN
                    if (reload_q != '0) begin
                        state_q <= RUN;
                        count_q <= reload_q;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end
`else
                    state_q <= IDLE;
                    count_q <= '0;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count_out = count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
